rf_host_ctrl: RTL and testbench

//   Initiator side of the register-file port: turns a nibble-wide command stream
//   (valid/ready) into rd/wr/reg_out/reg_in/data_in strobes for the register file.

---
 rtl/rf_host_ctrl.sv | 118 +++++++++++
 tb/tb_rf_host_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_host_ctrl.sv
// rf_host_ctrl: decodes a nibble-wide command stream into register-file
// read/write strobes and returns captured read data over a response handshake.
module rf_host_ctrl #(
  parameter int NUMRF = 2,
  parameter int SIZE  = 8,
  parameter int NIB   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [NIB-1:0]   cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SIZE-1:0]  rsp_data,
  output logic             err,
  output logic             busy,
  output logic             rf_wr,
  output logic             rf_rd,
  output logic [NUMRF-1:0] rf_reg_in,
  output logic [NUMRF-1:0] rf_reg_out,
  output logic [SIZE-1:0]  rf_data_in,
  input  logic [SIZE-1:0]  rf_data_out
);
  typedef enum logic [2:0] {IDLE, GET_LO, GET_HI, WRITE, READ, RESP} state_t;
  localparam logic [1:0] OP_WR = 2'b01, OP_RD = 2'b10, OP_RSV = 2'b11;
  state_t state_q, state_d;
  logic [NUMRF-1:0] reg_in_q, reg_in_d, reg_out_q, reg_out_d;
  logic [SIZE-1:0] data_in_q, data_in_d, rsp_data_q, rsp_data_d;
  logic err_q, err_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic busy_q, busy_d, wr_q, wr_d, rd_q, rd_d;
  logic fire;
  logic [1:0] op;
  assign fire = cmd_valid & ready_q;
  assign op = cmd_data[NIB-1:NIB-2];
  always_comb begin
    state_d = state_q;
    reg_in_d = reg_in_q;
    reg_out_d = reg_out_q;
    data_in_d = data_in_q;
    rsp_data_d = rsp_data_q;
    err_d = 1'b0;
    case (state_q)
      IDLE:
        if (fire) begin
          if (op == OP_WR) begin
            reg_in_d = cmd_data[NUMRF-1:0];
            state_d = GET_LO;
          end else if (op == OP_RD) begin
            reg_out_d = cmd_data[NUMRF-1:0];
            state_d = READ;
          end else if (op == OP_RSV) begin
            err_d = 1'b1;
          end
        end
      GET_LO:
        if (fire) begin
          data_in_d[NIB-1:0] = cmd_data;
          state_d = GET_HI;
        end
      GET_HI:
        if (fire) begin
          data_in_d[SIZE-1:NIB] = cmd_data;
          state_d = WRITE;
        end
      WRITE: state_d = IDLE;
      READ: begin
        rsp_data_d = rf_data_out;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    // Strobes/flags are registered as a function of the state being entered.
    ready_d = (state_d == IDLE) || (state_d == GET_LO) || (state_d == GET_HI);
    busy_d = state_d != IDLE;
    wr_d = state_d == WRITE;
    rd_d = state_d == READ;
    rsp_valid_d = state_d == RESP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      reg_in_q <= '0;
      reg_out_q <= '0;
      data_in_q <= '0;
      rsp_data_q <= '0;
      err_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_in_q <= reg_in_d;
      reg_out_q <= reg_out_d;
      data_in_q <= data_in_d;
      rsp_data_q <= rsp_data_d;
      err_q <= err_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign err = err_q;
  assign busy = busy_q;
  assign rf_wr = wr_q;
  assign rf_rd = rd_q;
  assign rf_reg_in = reg_in_q;
  assign rf_reg_out = reg_out_q;
  assign rf_data_in = data_in_q;
endmodule

// File: tb/tb_rf_host_ctrl.sv
// tb_rf_host_ctrl: directed sequences plus a vector table, with a register-file
// model and write/response scoreboards checked on the falling edge.
module tb_rf_host_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, err, busy, rf_wr, rf_rd;
  logic [7:0] rsp_data, rf_data_in, rf_data_out;
  logic [1:0] rf_reg_in, rf_reg_out;
  logic [7:0] rf_mem [4];
  int pass_cnt = 0, total_cnt = 0, wr_cnt = 0, err_cnt = 0;
  logic [9:0] wr_exp_q [$];
  logic [7:0] rd_exp_q [$];
  typedef struct {
    logic [3:0] hdr;
    logic [7:0] data;
    int gap;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [10];

  rf_host_ctrl #(.NUMRF(2), .SIZE(8), .NIB(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .err(err), .busy(busy), .rf_wr(rf_wr), .rf_rd(rf_rd),
    .rf_reg_in(rf_reg_in), .rf_reg_out(rf_reg_out), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;
  assign rf_data_out = rf_mem[rf_reg_out];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
    else if (rf_wr) rf_mem[rf_reg_in] <= rf_data_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] nib, input int gap);
    int n = 0;
    cmd_valid = 1'b0;
    repeat (gap) step();
    cmd_valid = 1'b1;
    cmd_data = nib;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", {31'd0, cmd_ready}, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] hdr, input logic [7:0] data, input int gap);
    wr_exp_q.push_back({hdr[1:0], data});
    send_beat(hdr, 0);
    send_beat(data[3:0], gap);
    send_beat(data[7:4], gap);
  endtask

  task automatic do_read(input logic [3:0] hdr, input logic [7:0] exp);
    int n = 0;
    rd_exp_q.push_back(exp);
    send_beat(hdr, 0);
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rsp_arrive", {31'd0, rsp_valid}, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, rsp_valid}, 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (err) err_cnt++;
      if (rf_wr) begin
        wr_cnt++;
        chk("wr_pending", {31'd0, wr_exp_q.size() > 0}, 1);
        if (wr_exp_q.size() > 0) chk("wr_scoreboard", {rf_reg_in, rf_data_in}, wr_exp_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_pending", {31'd0, rd_exp_q.size() > 0}, 1);
        if (rd_exp_q.size() > 0) chk("rsp_scoreboard", rsp_data, rd_exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, e0;
    vecs[0] = '{4'h4, 8'h11, 0, 8'h00};
    vecs[1] = '{4'h5, 8'h22, 1, 8'h00};
    vecs[2] = '{4'h6, 8'h33, 0, 8'h00};
    vecs[3] = '{4'h7, 8'h44, 3, 8'h00};
    vecs[4] = '{4'h0, 8'h00, 0, 8'h00};
    vecs[5] = '{4'h8, 8'h00, 0, 8'h11};
    vecs[6] = '{4'h9, 8'h00, 0, 8'h22};
    vecs[7] = '{4'hA, 8'h00, 0, 8'h33};
    vecs[8] = '{4'hB, 8'h00, 0, 8'h44};
    vecs[9] = '{4'h9, 8'h00, 0, 8'h22};
    // Reset state
    repeat (2) step();
    chk("rst_ctrl", {26'd0, cmd_ready, rsp_valid, err, busy, rf_wr, rf_rd}, 32'b100000);
    chk("rst_data", {12'd0, rf_reg_in, rf_reg_out, rf_data_in, rsp_data}, 0);
    rst_n = 1'b1;
    step();
    // Reset in the middle of GET_HI
    w0 = wr_cnt;
    send_beat(4'h6, 0);
    send_beat(4'h5, 0);
    chk("gethi_busy", {31'd0, busy}, 1);
    cmd_valid = 1'b1;
    cmd_data = 4'hA;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {26'd0, cmd_ready, rsp_valid, err, busy, rf_wr, rf_rd}, 32'b100000);
    chk("midrst_data", {12'd0, rf_reg_in, rf_reg_out, rf_data_in, rsp_data}, 0);
    cmd_valid = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("midrst_no_wr", wr_cnt, w0);
    // WRITE r2 = 0xA5, back-to-back beats
    do_write(4'h6, 8'hA5, 0);
    chk("wr_strobe", {31'd0, rf_wr}, 1);
    chk("wr_idx", rf_reg_in, 2);
    chk("wr_data", rf_data_in, 8'hA5);
    chk("wr_ready_low", {31'd0, cmd_ready}, 0);
    step();
    chk("wr_one_cycle", {29'd0, rf_wr, busy, cmd_ready}, 32'b001);
    // READ r2 with a stalled consumer
    rd_exp_q.push_back(8'hA5);
    send_beat(4'hA, 0);
    chk("rd_strobe", {31'd0, rf_rd}, 1);
    chk("rd_idx", rf_reg_out, 2);
    step();
    chk("rd_one_cycle", {31'd0, rf_rd}, 0);
    chk("rsp_valid", {31'd0, rsp_valid}, 1);
    chk("rsp_data", rsp_data, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rsp_hold", {22'd0, rsp_valid, cmd_ready, rsp_data}, {22'd0, 2'b10, 8'hA5});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_release", {30'd0, rsp_valid, busy}, 0);
    // Reserved opcode then NOP
    e0 = err_cnt;
    w0 = wr_cnt;
    send_beat(4'hF, 0);
    chk("err_pulse", {30'd0, err, busy}, 32'b10);
    send_beat(4'h0, 0);
    chk("err_clear", {28'd0, err, rf_wr, rf_rd, busy}, 0);
    repeat (3) step();
    chk("err_count", err_cnt - e0, 1);
    chk("rsv_no_wr", wr_cnt, w0);
    // WRITE with 2-cycle gaps between beats
    w0 = wr_cnt;
    wr_exp_q.push_back({2'd2, 8'hA5});
    send_beat(4'h6, 0);
    send_beat(4'h5, 2);
    cmd_valid = 1'b0;
    step();
    step();
    chk("gap_no_early_wr", wr_cnt, w0);
    chk("gap_wait", {30'd0, busy, cmd_ready}, 32'b11);
    send_beat(4'hA, 0);
    chk("gap_wr", {21'd0, rf_wr, rf_reg_in, rf_data_in}, {21'd0, 1'b1, 2'd2, 8'hA5});
    step();
    // Vector table: fill all registers, then read them back
    foreach (vecs[i]) begin
      if (vecs[i].hdr[3:2] == 2'b01) begin
        do_write(vecs[i].hdr, vecs[i].data, vecs[i].gap);
        step();
      end else if (vecs[i].hdr[3:2] == 2'b10) begin
        do_read(vecs[i].hdr, vecs[i].exp);
      end else begin
        send_beat(vecs[i].hdr, vecs[i].gap);
      end
      chk("vec_idle", {30'd0, busy, cmd_ready}, 32'b01);
    end
    repeat (2) step();
    chk("wr_queue_empty", wr_exp_q.size(), 0);
    chk("rd_queue_empty", rd_exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
